// File: rtl/branch_pkg.sv
// Shared branch encodings: func3 codes, 2-bit counter states and saturating helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator; latency 0, no backpressure.
// Reserved func3 codes (010/011) evaluate not-taken and flag illegal.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with one-stage registered EX resolution and saturating stats.
// Latency: prediction combinational, resolution 1 cycle; no backpressure, flush kills.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         PC_LSB      = 2,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              res_is_branch,
    input  logic [2:0]        res_func3,
    input  logic [XLEN-1:0]   res_rs1,
    input  logic [XLEN-1:0]   res_rs2,
    input  logic [XLEN-1:0]   res_pc,
    input  logic              res_pred_taken,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_mispredict,
    output logic              out_illegal,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]        r_bht [BHT_ENTRIES];
    logic              r_valid, r_taken, r_mis, r_illegal;
    logic [STAT_W-1:0] r_branches, r_mispredicts;

    logic [IDX_W-1:0]  w_pred_idx, w_res_idx;
    logic              w_cond_taken, w_cond_illegal;
    logic              w_accept, w_taken, w_illegal, w_mis, w_legal_br;
    logic              w_unused_pc;

    assign w_pred_idx  = pred_pc[PC_LSB +: IDX_W];
    assign w_res_idx   = res_pc[PC_LSB +: IDX_W];
    assign w_unused_pc = ^{pred_pc, res_pc};

    branch_cond #(.XLEN(XLEN)) u_cond (
        .func3   (res_func3),
        .rs1     (res_rs1),
        .rs2     (res_rs2),
        .taken   (w_cond_taken),
        .illegal (w_cond_illegal)
    );

    // Non-branches report nothing; an illegal branch mispredicts iff fetch guessed taken.
    assign w_accept   = res_valid & ~flush;
    assign w_taken    = res_is_branch & w_cond_taken;
    assign w_illegal  = res_is_branch & w_cond_illegal;
    assign w_mis      = res_is_branch & (w_taken ^ res_pred_taken);
    assign w_legal_br = w_accept & res_is_branch & ~w_cond_illegal;

    assign pred_taken = r_bht[w_pred_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
        end else if (w_legal_br) begin
            r_bht[w_res_idx] <= w_taken ? sat_inc(r_bht[w_res_idx]) : sat_dec(r_bht[w_res_idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_mis     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid   <= w_accept;
            r_taken   <= w_accept & w_taken;
            r_mis     <= w_accept & w_mis;
            r_illegal <= w_accept & w_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (stat_clear) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (w_legal_br) begin
            if (r_branches != '1)
                r_branches <= r_branches + 1'b1;
            if (w_mis && (r_mispredicts != '1))
                r_mispredicts <= r_mispredicts + 1'b1;
        end
    end

    assign out_valid        = r_valid;
    assign out_taken        = r_taken;
    assign out_mispredict   = r_mis;
    assign out_illegal      = r_illegal;
    assign stat_branches    = r_branches;
    assign stat_mispredicts = r_mispredicts;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; resolution outputs checked through a scoreboard queue.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid, res_is_branch, res_pred_taken, flush, stat_clear;
    logic [2:0]  res_func3;
    logic [31:0] res_rs1, res_rs2, res_pc;
    logic        out_valid, out_taken, out_mispredict, out_illegal;
    logic [3:0]  stat_branches, stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    branch_predict_unit #(
        .XLEN(32), .BHT_ENTRIES(64), .PC_LSB(2), .CNT_INIT(2'b01), .STAT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_func3(res_func3),
        .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pc(res_pc),
        .res_pred_taken(res_pred_taken), .flush(flush),
        .out_valid(out_valid), .out_taken(out_taken),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic req);
        pred_pc = pc;
        #1;
        chk(name, longint'(pred_taken), longint'(req));
    endtask

    task automatic expect_out(input logic t, input logic m, input logic i);
        exp_q.push_back({t, m, i});
    endtask

    task automatic drive(input logic v, input logic br, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic pred, input logic fl, input logic sc);
        res_valid = v; res_is_branch = br; res_func3 = f3;
        res_rs1 = a; res_rs2 = b; res_pc = pc;
        res_pred_taken = pred; flush = fl; stat_clear = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL out_unexpected: got out_valid=1, required no output");
                end else begin
                    e = exp_q.pop_front();
                    if ({out_taken, out_mispredict, out_illegal} !== e) begin
                        n_errors++;
                        $display("FAIL out_fields: got t/m/i=%b, required %b",
                                 {out_taken, out_mispredict, out_illegal}, e);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; pred_pc = 32'h40;
        res_valid = 0; res_is_branch = 0; res_func3 = 0; res_rs1 = 0; res_rs2 = 0;
        res_pc = 0; res_pred_taken = 0; flush = 0; stat_clear = 0;

        // 1: reset state
        #12;
        chk_pred("rst_pred_0x40", 32'h40, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_stat_mis", stat_mispredicts, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: first BEQ trains counter[16] to WT
        expect_out(1, 1, 0);
        drive(1, 1, 3'b000, 32'd10, 32'd10, 32'h40, 0, 0, 0);
        chk("t2_stat_mis", stat_mispredicts, 1);
        chk("t2_stat_br", stat_branches, 1);
        chk_pred("t2_pred", 32'h40, 1'b1);

        // 3: saturate up then walk down
        for (int k = 0; k < 4; k++) begin
            expect_out(1, 0, 0);
            drive(1, 1, 3'b000, 32'd7, 32'd7, 32'h40, 1, 0, 0);
            chk_pred("t3_pred_up", 32'h40, 1'b1);
        end
        expect_out(0, 1, 0);
        drive(1, 1, 3'b000, 32'd7, 32'd8, 32'h40, 1, 0, 0);
        chk_pred("t3_pred_dn1", 32'h40, 1'b1);
        expect_out(0, 1, 0);
        drive(1, 1, 3'b000, 32'd7, 32'd8, 32'h40, 1, 0, 0);
        chk_pred("t3_pred_dn2", 32'h40, 1'b0);

        // 4: signed vs unsigned compares, plus BNE/BGE
        expect_out(1, 1, 0);
        drive(1, 1, 3'b100, 32'hFFFF_FFFB, 32'd3, 32'h100, 0, 0, 0);
        expect_out(0, 0, 0);
        drive(1, 1, 3'b110, 32'hFFFF_FFFB, 32'd3, 32'h104, 0, 0, 0);
        expect_out(1, 0, 0);
        drive(1, 1, 3'b111, 32'd20, 32'd10, 32'h108, 1, 0, 0);
        expect_out(0, 0, 0);
        drive(1, 1, 3'b001, 32'd5, 32'd5, 32'h10C, 0, 0, 0);
        expect_out(1, 0, 0);
        drive(1, 1, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h110, 1, 0, 0);
        chk("t4_stat_br", stat_branches, 12);
        chk("t4_stat_mis", stat_mispredicts, 4);

        // 5: illegal func3, non-branch, and flushed instruction
        expect_out(0, 1, 1);
        drive(1, 1, 3'b010, 32'd1, 32'd1, 32'h80, 1, 0, 0);
        expect_out(0, 0, 0);
        drive(1, 0, 3'b000, 32'd9, 32'd9, 32'h80, 1, 0, 0);
        drive(1, 1, 3'b000, 32'd9, 32'd9, 32'h80, 0, 1, 0);
        chk("t5_stat_br", stat_branches, 12);
        chk("t5_stat_mis", stat_mispredicts, 4);
        idle();
        chk("t5_flush_valid", out_valid, 0);
        chk_pred("t5_flush_bht", 32'h80, 1'b0);

        // 6: stats saturate at 4'hF, clear beats increment
        for (int k = 0; k < 17; k++) begin
            expect_out(1, 1, 0);
            drive(1, 1, 3'b000, 32'd3, 32'd3, 32'h40, 0, 0, 0);
        end
        chk("t6_sat_br", stat_branches, 15);
        chk("t6_sat_mis", stat_mispredicts, 15);
        expect_out(1, 1, 0);
        drive(1, 1, 3'b000, 32'd3, 32'd3, 32'h40, 0, 0, 1);
        chk("t6_clr_br", stat_branches, 0);
        chk("t6_clr_mis", stat_mispredicts, 0);
        expect_out(1, 1, 0);
        drive(1, 1, 3'b000, 32'd3, 32'd3, 32'h40, 0, 0, 0);
        chk("t6_post_br", stat_branches, 1);
        chk("t6_post_mis", stat_mispredicts, 1);
        idle();
        chk_pred("t6_pre_rst_pred", 32'h40, 1'b1);

        // mid-stream async reset with an instruction in flight
        res_valid = 1; res_is_branch = 1; res_func3 = 3'b000;
        res_rs1 = 32'd1; res_rs2 = 32'd1; res_pc = 32'h40; res_pred_taken = 0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_br", stat_branches, 0);
        chk("t6_rst_mis", stat_mispredicts, 0);
        chk_pred("t6_rst_pred40", 32'h40, 1'b0);
        chk_pred("t6_rst_pred108", 32'h108, 1'b0);
        res_valid = 0;
        #2 rst_n = 1'b1;
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
